// File: rtl/mem_bus_responder.sv
// mem_bus_responder
//   Collects a 4-beat byte-serial bus frame (address + write data, LSB byte
//   first) and issues one 32-bit memory request. It then waits for mem_ready
//   with a timeout and returns a 4-beat byte-serial response: the read data,
//   the echoed write data, or 32'hDEAD_BEEF when the memory timed out.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   bus_start       beat 0 marker of an inbound frame
//   bus_we          frame type on beat 0 (1 = write, 0 = read)
//   bus_addr_in     address byte of the current beat
//   bus_wdata_in    write-data byte of the current beat
//   bus_rdata_out   response byte (8'h00 when bus_rdata_oe = 0)
//   bus_rdata_oe    high during the 4 response beats
//   mem_addr        assembled address, held until the next request
//   mem_wdata       assembled write data, held until the next request
//   mem_re, mem_we  one-cycle read / write request pulses
//   mem_rdata       memory read data, valid with mem_ready
//   mem_ready       memory completion
//   busy            high whenever the FSM is not in IDLE
//   frame_err       sticky: stray start or timeout; cleared by the next start
//
// Parameter
//   WAIT_MAX        cycles (counted from REQ) to wait for mem_ready, 1..255
//
// State  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for bus_start; beat 0 captured on the way out
// RX     | capturing beats 1..3
// REQ    | one-cycle memory request; mem_ready already sampled here
// WAIT   | waiting for mem_ready or the timeout
// RESP   | driving 4 response bytes
module mem_bus_responder #(
   parameter int unsigned WAIT_MAX = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        bus_start,
   input  logic        bus_we,
   input  logic [7:0]  bus_addr_in,
   input  logic [7:0]  bus_wdata_in,
   output logic [7:0]  bus_rdata_out,
   output logic        bus_rdata_oe,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_re,
   output logic        mem_we,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic        busy,
   output logic        frame_err
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RX   = 3'd1,
      S_REQ  = 3'd2,
      S_WAIT = 3'd3,
      S_RESP = 3'd4
   } state_t;

   localparam logic [7:0]  WAIT_LIM     = 8'(WAIT_MAX);
   localparam logic [31:0] TIMEOUT_WORD = 32'hDEAD_BEEF;

   state_t      state,         state_nxt;
   logic [31:0] addr_sr,       addr_sr_nxt;
   logic [31:0] wdata_sr,      wdata_sr_nxt;
   logic [23:0] resp_sr,       resp_sr_nxt;
   logic [1:0]  beat_cnt,      beat_cnt_nxt;
   logic [7:0]  wait_cnt,      wait_cnt_nxt;
   logic        we_q,          we_q_nxt;

   logic [7:0]  rdata_out_nxt;
   logic        rdata_oe_nxt;
   logic [31:0] mem_addr_nxt;
   logic [31:0] mem_wdata_nxt;
   logic        mem_re_nxt;
   logic        mem_we_nxt;
   logic        busy_nxt;
   logic        frame_err_nxt;
   logic [31:0] resp_word;
   logic [4:0]  lane_lsb;

   assign lane_lsb = {beat_cnt, 3'b000};

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         addr_sr       <= '0;
         wdata_sr      <= '0;
         resp_sr       <= '0;
         beat_cnt      <= '0;
         wait_cnt      <= '0;
         we_q          <= 1'b0;
         bus_rdata_out <= '0;
         bus_rdata_oe  <= 1'b0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         mem_re        <= 1'b0;
         mem_we        <= 1'b0;
         busy          <= 1'b0;
         frame_err     <= 1'b0;
      end else begin
         state         <= state_nxt;
         addr_sr       <= addr_sr_nxt;
         wdata_sr      <= wdata_sr_nxt;
         resp_sr       <= resp_sr_nxt;
         beat_cnt      <= beat_cnt_nxt;
         wait_cnt      <= wait_cnt_nxt;
         we_q          <= we_q_nxt;
         bus_rdata_out <= rdata_out_nxt;
         bus_rdata_oe  <= rdata_oe_nxt;
         mem_addr      <= mem_addr_nxt;
         mem_wdata     <= mem_wdata_nxt;
         mem_re        <= mem_re_nxt;
         mem_we        <= mem_we_nxt;
         busy          <= busy_nxt;
         frame_err     <= frame_err_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      addr_sr_nxt   = addr_sr;
      wdata_sr_nxt  = wdata_sr;
      resp_sr_nxt   = resp_sr;
      beat_cnt_nxt  = beat_cnt;
      wait_cnt_nxt  = wait_cnt;
      we_q_nxt      = we_q;
      rdata_out_nxt = 8'h00;
      rdata_oe_nxt  = 1'b0;
      mem_addr_nxt  = mem_addr;
      mem_wdata_nxt = mem_wdata;
      mem_re_nxt    = 1'b0;
      mem_we_nxt    = 1'b0;
      busy_nxt      = busy;
      frame_err_nxt = frame_err;
      resp_word     = TIMEOUT_WORD;

      case (state)
         S_IDLE: begin
            busy_nxt = 1'b0;
            if (bus_start) begin
               state_nxt     = S_RX;
               addr_sr_nxt   = {24'h0, bus_addr_in};
               wdata_sr_nxt  = {24'h0, bus_wdata_in};
               we_q_nxt      = bus_we;
               frame_err_nxt = 1'b0;
               beat_cnt_nxt  = 2'd1;
               busy_nxt      = 1'b1;
            end
         end

         S_RX: begin
            addr_sr_nxt[lane_lsb +: 8]  = bus_addr_in;
            wdata_sr_nxt[lane_lsb +: 8] = bus_wdata_in;
            beat_cnt_nxt                = beat_cnt + 2'd1;
            if (beat_cnt == 2'd3) begin
               // The last byte goes straight into the registered request so
               // that mem_addr/mem_wdata are already complete in REQ.
               state_nxt     = S_REQ;
               mem_addr_nxt  = {bus_addr_in,  addr_sr[23:0]};
               mem_wdata_nxt = {bus_wdata_in, wdata_sr[23:0]};
               mem_re_nxt    = ~we_q;
               mem_we_nxt    = we_q;
               wait_cnt_nxt  = 8'd1;
            end
         end

         S_REQ, S_WAIT: begin
            if (mem_ready || (wait_cnt >= WAIT_LIM)) begin
               if (mem_ready) begin
                  resp_word = we_q ? mem_wdata : mem_rdata;
               end else begin
                  resp_word     = TIMEOUT_WORD;
                  frame_err_nxt = 1'b1;
               end
               state_nxt     = S_RESP;
               rdata_out_nxt = resp_word[7:0];
               rdata_oe_nxt  = 1'b1;
               resp_sr_nxt   = resp_word[31:8];
               beat_cnt_nxt  = 2'd0;
            end else begin
               state_nxt    = S_WAIT;
               wait_cnt_nxt = wait_cnt + 8'd1;
            end
         end

         S_RESP: begin
            if (beat_cnt == 2'd3) begin
               state_nxt = S_IDLE;
               busy_nxt  = 1'b0;
            end else begin
               rdata_out_nxt = resp_sr[7:0];
               rdata_oe_nxt  = 1'b1;
               resp_sr_nxt   = {8'h00, resp_sr[23:8]};
               beat_cnt_nxt  = beat_cnt + 2'd1;
            end
         end

         default: begin
            state_nxt = S_IDLE;
            busy_nxt  = 1'b0;
         end
      endcase

      // A start that arrives while a frame is in flight is only flagged.
      if (bus_start && (state != S_IDLE)) begin
         frame_err_nxt = 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_bus_responder.sv
module tb_mem_bus_responder;

   localparam int WAIT_MAX = 15;

   logic        clk = 1'b0;
   logic        rst;
   logic        bus_start;
   logic        bus_we;
   logic [7:0]  bus_addr_in;
   logic [7:0]  bus_wdata_in;
   logic [7:0]  bus_rdata_out;
   logic        bus_rdata_oe;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_re;
   logic        mem_we;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        busy;
   logic        frame_err;

   mem_bus_responder #(.WAIT_MAX(WAIT_MAX)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus_start    (bus_start),
      .bus_we       (bus_we),
      .bus_addr_in  (bus_addr_in),
      .bus_wdata_in (bus_wdata_in),
      .bus_rdata_out(bus_rdata_out),
      .bus_rdata_oe (bus_rdata_oe),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_re       (mem_re),
      .mem_we       (mem_we),
      .mem_rdata    (mem_rdata),
      .mem_ready    (mem_ready),
      .busy         (busy),
      .frame_err    (frame_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int         cyc;
      logic [7:0] b;
   } beat_t;

   typedef struct {
      int          cyc;
      logic        re;
      logic        we;
      logic [31:0] a;
      logic [31:0] w;
   } req_t;

   beat_t beat_q[$];
   req_t  req_q[$];

   // memory model controls
   int          ready_delay = 0;
   logic [31:0] rdata_val   = '0;
   bit          force_ready = 1'b0;
   int          pend        = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // memory responder: mem_ready 'ready_delay' cycles after the request
   initial begin
      mem_ready = 1'b0;
      mem_rdata = 32'h1111_2222;
      forever begin
         @(negedge clk);
         mem_ready = force_ready;
         if ((mem_re || mem_we) && (ready_delay >= 0)) begin
            if (ready_delay == 0) begin
               mem_ready = 1'b1;
               mem_rdata = rdata_val;
            end else begin
               pend = ready_delay;
            end
         end else if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               mem_ready = 1'b1;
               mem_rdata = rdata_val;
            end
         end
      end
   end

   // monitor / scoreboard
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (bus_rdata_oe) begin
               if (beat_q.size() == 0) begin
                  chk("unexpected_beat", {24'h0, bus_rdata_out}, 32'hFFFF_FFFF);
               end else begin
                  beat_t e;
                  e = beat_q.pop_front();
                  chk("beat_data", {24'h0, bus_rdata_out}, {24'h0, e.b});
                  chk("beat_cycle", cyc, e.cyc);
               end
            end else if (bus_rdata_out !== 8'h00) begin
               chk("rdata_idle_zero", {24'h0, bus_rdata_out}, 32'h0);
            end
            if (mem_re || mem_we) begin
               if (req_q.size() == 0) begin
                  chk("unexpected_req", {30'h0, mem_re, mem_we}, 32'h0);
               end else begin
                  req_t r;
                  r = req_q.pop_front();
                  chk("req_cycle", cyc, r.cyc);
                  chk("req_type", {30'h0, mem_re, mem_we}, {30'h0, r.re, r.we});
                  chk("mem_addr", mem_addr, r.a);
                  chk("mem_wdata", mem_wdata, r.w);
               end
            end
         end
      end
   end

   task automatic wait_until(input int target);
      while (cyc < target) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Issue one frame starting in the current cycle T; pushes expectations.
   // Returns the cycle at which the DUT is idle again (T+9+waits).
   task automatic send_frame(input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdata,
                             input int delay, input bit stray, output int t_idle);
      int          t0;
      int          w;
      logic [31:0] resp;
      req_t        r;
      beat_t       b;
      t0 = cyc;
      if (delay < 0 || delay >= WAIT_MAX) begin
         w    = WAIT_MAX - 1;
         resp = 32'hDEAD_BEEF;
      end else begin
         w    = delay;
         resp = we ? wdata : rdata;
      end
      r.cyc = t0 + 4; r.re = ~we; r.we = we; r.a = addr; r.w = wdata;
      req_q.push_back(r);
      for (int i = 0; i < 4; i++) begin
         b.cyc = t0 + 5 + w + i;
         b.b   = resp[8*i +: 8];
         beat_q.push_back(b);
      end
      ready_delay = delay;
      rdata_val   = rdata;
      for (int i = 0; i < 4; i++) begin
         bus_start    = (i == 0) || (stray && i == 2);
         bus_we       = (i == 0) ? we : ~we;
         bus_addr_in  = addr[8*i +: 8];
         bus_wdata_in = wdata[8*i +: 8];
         if (i == 1) begin
            @(negedge clk);
            chk("frame_err_cleared_on_start", {31'h0, frame_err}, 32'h0);
            chk("busy_after_start", {31'h0, busy}, 32'h1);
         end
         @(posedge clk);
         #1;
      end
      bus_start    = 1'b0;
      bus_we       = 1'b0;
      bus_addr_in  = 8'hA5;
      bus_wdata_in = 8'h5A;
      if (stray) begin
         @(negedge clk);
         chk("frame_err_stray", {31'h0, frame_err}, 32'h1);
      end
      t_idle = t0 + 9 + w;
   endtask

   task automatic check_idle(input string name, input int t_idle, input logic err_exp);
      wait_until(t_idle - 1);
      @(negedge clk);
      chk({name, "_busy_last_beat"}, {31'h0, busy}, 32'h1);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk({name, "_busy_idle"}, {31'h0, busy}, 32'h0);
      chk({name, "_frame_err"}, {31'h0, frame_err}, {31'h0, err_exp});
   endtask

   task automatic check_all_zero(input string name);
      chk({name, "_rdata"}, {24'h0, bus_rdata_out}, 32'h0);
      chk({name, "_oe"}, {31'h0, bus_rdata_oe}, 32'h0);
      chk({name, "_mem_addr"}, mem_addr, 32'h0);
      chk({name, "_mem_wdata"}, mem_wdata, 32'h0);
      chk({name, "_re_we"}, {30'h0, mem_re, mem_we}, 32'h0);
      chk({name, "_busy"}, {31'h0, busy}, 32'h0);
      chk({name, "_frame_err"}, {31'h0, frame_err}, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int t_idle;
      int t0;
      rst          = 1'b1;
      bus_start    = 1'b1;
      bus_we       = 1'b1;
      bus_addr_in  = 8'h33;
      bus_wdata_in = 8'h44;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check_all_zero("reset");
      @(posedge clk);
      #1;
      rst       = 1'b0;
      bus_start = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("start_with_rst_ignored", {31'h0, busy}, 32'h0);
      @(posedge clk);
      #1;

      // read, zero wait
      send_frame(1'b0, 32'h1234_5678, 32'h0BAD_F00D, 32'hCAFE_F00D, 0, 1'b0, t_idle);
      check_idle("read0", t_idle, 1'b0);
      wait_until(t_idle + 1);

      // write, 3 wait cycles: echo of write data
      send_frame(1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'h1357_9BDF, 3, 1'b0, t_idle);
      check_idle("write3", t_idle, 1'b0);
      wait_until(t_idle + 2);

      // ready on the last allowed cycle
      send_frame(1'b0, 32'hA0B0_C0D0, 32'h0, 32'h0102_0304, WAIT_MAX - 1, 1'b0, t_idle);
      check_idle("edge_ok", t_idle, 1'b0);
      wait_until(t_idle + 1);

      // timeout: ready one cycle too late is ignored
      send_frame(1'b0, 32'h5555_AAAA, 32'h0, 32'h7777_8888, WAIT_MAX, 1'b0, t_idle);
      check_idle("timeout", t_idle, 1'b1);
      wait_until(t_idle + 3);
      @(negedge clk);
      chk("frame_err_sticky", {31'h0, frame_err}, 32'h1);
      @(posedge clk);
      #1;

      // back-to-back: second start exactly when IDLE is reached
      send_frame(1'b1, 32'hFEED_0001, 32'h8765_4321, 32'h0, 0, 1'b0, t_idle);
      wait_until(t_idle);
      send_frame(1'b0, 32'hFEED_0002, 32'h0, 32'h2468_ACE0, 0, 1'b0, t_idle);
      check_idle("b2b", t_idle, 1'b0);
      wait_until(t_idle + 1);

      // stray start in beat 2
      send_frame(1'b0, 32'h9ABC_DEF0, 32'h0F0F_0F0F, 32'h600D_CAFE, 1, 1'b1, t_idle);
      check_idle("stray", t_idle, 1'b1);
      wait_until(t_idle + 1);

      // reset mid-frame (stray start in beat 1 sets frame_err beforehand)
      t0 = cyc;
      for (int i = 0; i < 3; i++) begin
         bus_start    = (i < 2);
         bus_we       = 1'b0;
         bus_addr_in  = 8'h10 + 8'(i);
         bus_wdata_in = 8'h20 + 8'(i);
         rst          = (i == 2);
         @(posedge clk);
         #1;
      end
      rst         = 1'b0;
      bus_start   = 1'b0;
      force_ready = 1'b1;
      @(negedge clk);
      chk("rst_mid_cycle", cyc, t0 + 3);
      check_all_zero("rst_mid");
      repeat (8) @(posedge clk);
      #1;
      force_ready = 1'b0;
      @(negedge clk);
      chk("rst_mid_still_idle", {31'h0, busy}, 32'h0);
      @(posedge clk);
      #1;

      // fresh frame after reset
      send_frame(1'b1, 32'h0BEE_F00D, 32'hC001_D00D, 32'h0, 2, 1'b0, t_idle);
      check_idle("post_rst", t_idle, 1'b0);

      repeat (4) @(posedge clk);
      #1;
      chk("beat_queue_empty", beat_q.size(), 32'h0);
      chk("req_queue_empty", req_q.size(), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
